// File: rtl/serial_word_receiver.sv
// Serial word receiver: synchronizes cs_n/sclk/sdi into clk and deserializes
// MSB-first words, pulsing data_valid on completion and frame_error on short frames.
module serial_word_receiver #(
  parameter int unsigned width       = 8,
  parameter int unsigned sync_stages = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs_n,
  input  logic             sclk,
  input  logic             sdi,
  output logic [width-1:0] parallelout,
  output logic             data_valid,
  output logic             frame_error,
  output logic             busy
);

  localparam int unsigned cnt_w = (width > 1) ? $clog2(width) : 1;
  localparam logic [cnt_w-1:0] last_bit = cnt_w'(width - 1);

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  state_t state;
  state_t next_state;

  logic [sync_stages-1:0] cs_sync;
  logic [sync_stages-1:0] sclk_sync;
  logic [sync_stages-1:0] sdi_sync;
  logic                   sclk_d;
  logic                   cs_s;
  logic                   sclk_s;
  logic                   sdi_s;
  logic                   sclk_edge;

  // Only width-1 bits are stored; the newest bit is appended combinationally.
  logic [width-2:0]       shift;
  logic [width-1:0]       shifted;
  logic [cnt_w-1:0]       bit_count;
  logic                   take_bit;
  logic                   frame_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      sdi_sync  <= '0;
      sclk_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[sync_stages-2:0], cs_n};
      sclk_sync <= {sclk_sync[sync_stages-2:0], sclk};
      sdi_sync  <= {sdi_sync[sync_stages-2:0], sdi};
      sclk_d    <= sclk_s;
    end
  end

  always_comb begin
    cs_s      = cs_sync[sync_stages-1];
    sclk_s    = sclk_sync[sync_stages-1];
    sdi_s     = sdi_sync[sync_stages-1];
    sclk_edge = sclk_s & ~sclk_d;
    shifted   = {shift, sdi_s};
    // Edges coinciding with a cs_s change are dropped: IDLE or frame end wins.
    take_bit  = (state == RECV) && !cs_s && sclk_edge;
    frame_end = (state == RECV) && cs_s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!cs_s) next_state = RECV;
      RECV:    if (cs_s)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RECV);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift       <= '0;
      bit_count   <= '0;
      parallelout <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      if (frame_end) begin
        if (bit_count != '0) frame_error <= 1'b1;
        bit_count <= '0;
      end else if (take_bit) begin
        shift <= shifted[width-2:0];
        if (bit_count == last_bit) begin
          parallelout <= shifted;
          data_valid  <= 1'b1;
          bit_count   <= '0;
        end else begin
          bit_count <= bit_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver: framed words, back-to-back,
// aborted frames, deselected activity, held sclk and mid-word reset.
module tb_serial_word_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs_n;
  logic       sclk;
  logic       sdi;
  logic [7:0] parallelout;
  logic       data_valid;
  logic       frame_error;
  logic       busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  int unsigned dv_cnt   = 0;
  int unsigned fe_cnt   = 0;
  int unsigned long_cnt = 0;
  int unsigned both_cnt = 0;
  logic [7:0]  last_word = '0;
  logic        prev_dv   = 1'b0;
  logic        prev_fe   = 1'b0;

  int unsigned dv0;
  int unsigned fe0;

  serial_word_receiver #(.width(8), .sync_stages(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .cs_n       (cs_n),
    .sclk       (sclk),
    .sdi        (sdi),
    .parallelout(parallelout),
    .data_valid (data_valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      dv_cnt    <= dv_cnt + 1;
      last_word <= parallelout;
    end
    if (frame_error === 1'b1) fe_cnt <= fe_cnt + 1;
    if ((data_valid === 1'b1 && prev_dv) || (frame_error === 1'b1 && prev_fe))
      long_cnt <= long_cnt + 1;
    if (data_valid === 1'b1 && frame_error === 1'b1) both_cnt <= both_cnt + 1;
    prev_dv <= (data_valid === 1'b1);
    prev_fe <= (frame_error === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int lo, input int hi);
    sclk = 1'b0;
    sdi  = b;
    idle(lo);
    sclk = 1'b1;
    idle(hi);
  endtask

  task automatic send_word(input logic [7:0] w, input int lo, input int hi);
    for (int i = 7; i >= 0; i--) send_bit(w[i], lo, hi);
    sclk = 1'b0;
  endtask

  task automatic mark;
    idle(1);
    dv0 = dv_cnt;
    fe0 = fe_cnt;
  endtask

  initial begin
    reset = 1'b1;
    cs_n  = 1'b1;
    sclk  = 1'b0;
    sdi   = 1'b0;
    idle(3);
    check("rst_parallelout", parallelout, 8'h00);
    check("rst_data_valid", data_valid, 1'b0);
    check("rst_frame_error", frame_error, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    idle(3);

    // single word
    mark();
    cs_n = 1'b0;
    idle(5);
    check("single_busy", busy, 1'b1);
    send_word(8'hA5, 4, 4);
    idle(8);
    check("single_dv_count", dv_cnt - dv0, 1);
    check("single_word", last_word, 8'hA5);
    check("single_parallelout", parallelout, 8'hA5);
    cs_n = 1'b1;
    idle(6);
    check("single_busy_low", busy, 1'b0);
    check("single_no_fe", fe_cnt - fe0, 0);

    // back-to-back within one frame
    mark();
    cs_n = 1'b0;
    idle(4);
    send_word(8'hA5, 4, 4);
    check("b2b_first", parallelout, 8'hA5);
    send_word(8'h4A, 4, 4);
    idle(8);
    check("b2b_second", parallelout, 8'h4A);
    check("b2b_dv_count", dv_cnt - dv0, 2);
    cs_n = 1'b1;
    idle(8);
    check("b2b_no_fe", fe_cnt - fe0, 0);

    // aborted frame
    mark();
    cs_n = 1'b0;
    idle(4);
    send_word(8'hA5, 4, 4);
    send_bit(1'b1, 4, 4);
    send_bit(1'b0, 4, 4);
    send_bit(1'b1, 4, 4);
    sclk = 1'b0;
    idle(4);
    cs_n = 1'b1;
    idle(8);
    check("abort_fe_count", fe_cnt - fe0, 1);
    check("abort_dv_count", dv_cnt - dv0, 1);
    check("abort_parallelout", parallelout, 8'hA5);
    mark();
    cs_n = 1'b0;
    idle(4);
    send_word(8'h3C, 4, 4);
    idle(8);
    cs_n = 1'b1;
    idle(8);
    check("after_abort_word", parallelout, 8'h3C);
    check("after_abort_dv", dv_cnt - dv0, 1);
    check("after_abort_no_fe", fe_cnt - fe0, 0);

    // deselected activity
    mark();
    for (int i = 0; i < 16; i++) begin
      sdi  = 1'($urandom_range(0, 1));
      sclk = ~sclk;
      idle(3);
    end
    idle(6);
    check("desel_no_dv", dv_cnt - dv0, 0);
    check("desel_no_fe", fe_cnt - fe0, 0);
    check("desel_parallelout", parallelout, 8'h3C);
    check("desel_busy", busy, 1'b0);

    // held sclk
    mark();
    cs_n = 1'b0;
    idle(4);
    send_word(8'hF0, 4, 20);
    idle(8);
    check("held_dv_count", dv_cnt - dv0, 1);
    check("held_word", parallelout, 8'hF0);
    cs_n = 1'b1;
    idle(8);
    check("held_no_fe", fe_cnt - fe0, 0);

    // reset mid-word with cs_n still low
    mark();
    cs_n = 1'b0;
    idle(4);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 4, 4);
    sclk = 1'b0;
    idle(4);
    reset = 1'b1;
    #1;
    check("midrst_parallelout", parallelout, 8'h00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_dv", data_valid, 1'b0);
    check("midrst_fe", frame_error, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    idle(4);
    send_word(8'h81, 4, 4);
    idle(8);
    check("midrst_word", parallelout, 8'h81);
    check("midrst_dv_count", dv_cnt - dv0, 1);
    cs_n = 1'b1;
    idle(8);
    check("midrst_no_fe", fe_cnt - fe0, 0);

    check("pulse_width_one", long_cnt, 0);
    check("dv_fe_exclusive", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
